// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: arbitrates per-stage stall and flush requests,
// drives the fetch redirect handshake, and keeps stall/flush counters plus a stall watchdog.
module pipe_hazard_ctrl #(
    parameter int STAGES  = 5,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STAGES-1:0]      stall_req,
    input  logic [STAGES-1:0]      flush_req,
    input  logic [STAGES*PC_W-1:0] flush_pc,
    output logic [STAGES-1:0]      stall,
    output logic [STAGES-1:0]      flush,
    output logic [STAGES-1:0]      bubble,
    output logic                   pc_stall,
    output logic                   redirect_valid,
    output logic [PC_W-1:0]        redirect_pc,
    input  logic                   redirect_ready,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic [CNT_W-1:0]       flush_events,
    output logic                   stall_timeout
);

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    localparam int RUN_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_events_q, flush_events_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              stall_timeout_q, stall_timeout_d;

    logic [STAGES-1:0] stall_mask;
    logic [STAGES-1:0] flush_mask;
    logic [STAGES-1:0] stall_int;
    logic [STAGES-1:0] flush_int;
    logic [STAGES-1:0] bubble_int;
    logic [PC_W-1:0]   sel_pc;
    logic              flush_acc;
    logic              any_stall;
    logic              s_acc;
    logic              f_acc;

    // stall_mask covers stages 0..k, flush_mask covers stages strictly below the oldest flusher;
    // the flush wins only when every stalled stage lies inside the flush window (f > k).
    always_comb begin
        stall_mask = '0;
        flush_mask = '0;
        s_acc      = 1'b0;
        f_acc      = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            s_acc         = s_acc | stall_req[i];
            stall_mask[i] = s_acc;
            flush_mask[i] = f_acc;
            f_acc         = f_acc | flush_req[i];
        end

        sel_pc = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush_req[i]) begin
                sel_pc = flush_pc[i*PC_W +: PC_W];
            end
        end

        flush_acc = (|flush_req) && ((stall_mask & ~flush_mask) == '0);
        stall_int = flush_acc ? '0 : stall_mask;
        flush_int = flush_acc ? flush_mask : '0;
        if (state_q == REDIRECT) begin
            flush_int[0] = 1'b1;
        end

        bubble_int = '0;
        for (int i = 1; i < STAGES; i++) begin
            bubble_int[i] = stall_int[i-1] & ~stall_int[i] & ~flush_int[i];
        end
        any_stall = |stall_int;
    end

    always_comb begin
        stall          = rst ? '0 : stall_int;
        flush          = rst ? '0 : flush_int;
        bubble         = rst ? '0 : bubble_int;
        pc_stall       = ~rst & (stall_int[0] | flush_acc | (state_q == REDIRECT));
        redirect_valid = ~rst & (state_q == REDIRECT);
        redirect_pc    = rst ? '0 : redirect_pc_q;
        stall_cycles   = rst ? '0 : stall_cycles_q;
        flush_events   = rst ? '0 : flush_events_q;
        stall_timeout  = ~rst & stall_timeout_q;
    end

    // A new accepted flush always reloads the target, even if the pending redirect is taken now.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        if (flush_acc) begin
            state_d       = REDIRECT;
            redirect_pc_d = sel_pc;
        end else if ((state_q == REDIRECT) && redirect_ready) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        flush_events_d  = flush_events_q;
        run_d           = run_q;
        stall_timeout_d = stall_timeout_q;
        if (cnt_clr) begin
            stall_cycles_d  = '0;
            flush_events_d  = '0;
            run_d           = '0;
            stall_timeout_d = 1'b0;
        end else begin
            if (any_stall && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
            if (flush_acc && (flush_events_q != '1)) begin
                flush_events_d = flush_events_q + CNT_W'(1);
            end
            // The run counter parks at TIMEOUT so a very long stall cannot wrap it.
            if (any_stall) begin
                if (run_q != RUN_W'(TIMEOUT)) begin
                    run_d = run_q + RUN_W'(1);
                end
                if ((TIMEOUT != 0) && (run_d == RUN_W'(TIMEOUT))) begin
                    stall_timeout_d = 1'b1;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            redirect_pc_q   <= '0;
            stall_cycles_q  <= '0;
            flush_events_q  <= '0;
            run_q           <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            redirect_pc_q   <= redirect_pc_d;
            stall_cycles_q  <= stall_cycles_d;
            flush_events_q  <= flush_events_d;
            run_q           <= run_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// each cycle's expectation comes from a stage-index reference model.
module tb_pipe_hazard_ctrl;

    localparam int STAGES  = 5;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst;
    logic [STAGES-1:0]      stall_req;
    logic [STAGES-1:0]      flush_req;
    logic [STAGES*PC_W-1:0] flush_pc;
    logic [STAGES-1:0]      stall;
    logic [STAGES-1:0]      flush;
    logic [STAGES-1:0]      bubble;
    logic                   pc_stall;
    logic                   redirect_valid;
    logic [PC_W-1:0]        redirect_pc;
    logic                   redirect_ready;
    logic                   cnt_clr;
    logic [CNT_W-1:0]       stall_cycles;
    logic [CNT_W-1:0]       flush_events;
    logic                   stall_timeout;

    typedef struct packed {
        logic [STAGES-1:0] stall;
        logic [STAGES-1:0] flush;
        logic [STAGES-1:0] bubble;
        logic              pc_stall;
        logic              rv;
        logic [PC_W-1:0]   rpc;
        logic [CNT_W-1:0]  sc;
        logic [CNT_W-1:0]  fe;
        logic              to;
    } exp_t;

    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    bit              m_redir;
    logic [PC_W-1:0] m_rpc;
    int              m_sc;
    int              m_fe;
    int              m_run;
    bit              m_to;

    pipe_hazard_ctrl #(
        .STAGES (STAGES),
        .PC_W   (PC_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .flush_req     (flush_req),
        .flush_pc      (flush_pc),
        .stall         (stall),
        .flush         (flush),
        .bubble        (bubble),
        .pc_stall      (pc_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_ready(redirect_ready),
        .cnt_clr       (cnt_clr),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [STAGES*PC_W-1:0] pc_at(input int idx, input logic [PC_W-1:0] v);
        logic [STAGES*PC_W-1:0] r;
        r = '0;
        r[idx*PC_W +: PC_W] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        chk("stall",          32'(stall),          32'(e.stall));
        chk("flush",          32'(flush),          32'(e.flush));
        chk("bubble",         32'(bubble),         32'(e.bubble));
        chk("pc_stall",       32'(pc_stall),       32'(e.pc_stall));
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        chk("redirect_pc",    32'(redirect_pc),    32'(e.rpc));
        chk("stall_cycles",   32'(stall_cycles),   32'(e.sc));
        chk("flush_events",   32'(flush_events),   32'(e.fe));
        chk("stall_timeout",  32'(stall_timeout),  32'(e.to));
    endtask

    // Drives one cycle of inputs just after the rising edge, queues what the outputs must be
    // during that cycle, then advances the reference model across the following edge.
    task automatic applyStimulus(input logic r, input logic [STAGES-1:0] sreq,
                                 input logic [STAGES-1:0] freq,
                                 input logic [STAGES*PC_W-1:0] fpc,
                                 input logic rdy, input logic clr);
        exp_t e;
        int   k;
        int   f;
        bit   acc;
        @(posedge clk);
        #1;
        rst            = r;
        stall_req      = sreq;
        flush_req      = freq;
        flush_pc       = fpc;
        redirect_ready = rdy;
        cnt_clr        = clr;

        k = -1;
        f = -1;
        for (int i = 0; i < STAGES; i++) begin
            if (sreq[i]) k = i;
            if (freq[i]) f = i;
        end
        acc = (f >= 0) && ((k < 0) || (f > k));

        e = '0;
        if (!r) begin
            for (int j = 0; j < STAGES; j++) begin
                e.stall[j] = !acc && (j <= k);
                e.flush[j] = acc && (j < f);
            end
            if (m_redir) e.flush[0] = 1'b1;
            for (int j = 1; j < STAGES; j++) begin
                e.bubble[j] = e.stall[j-1] && !e.stall[j] && !e.flush[j];
            end
            e.pc_stall = e.stall[0] || acc || m_redir;
            e.rv       = m_redir;
            e.rpc      = m_rpc;
            e.sc       = CNT_W'(m_sc);
            e.fe       = CNT_W'(m_fe);
            e.to       = m_to;
        end
        sbq.push_back(e);

        if (r) begin
            m_redir = 0;
            m_rpc   = '0;
            m_sc    = 0;
            m_fe    = 0;
            m_run   = 0;
            m_to    = 0;
        end else begin
            if (clr) begin
                m_sc  = 0;
                m_fe  = 0;
                m_run = 0;
                m_to  = 0;
            end else begin
                if ((e.stall != '0) && (m_sc < CNT_MAX)) m_sc++;
                if (acc && (m_fe < CNT_MAX)) m_fe++;
                if (e.stall != '0) begin
                    m_run++;
                    if (m_run >= TIMEOUT) m_to = 1;
                end else begin
                    m_run = 0;
                end
            end
            if (acc) begin
                m_redir = 1;
                m_rpc   = fpc[f*PC_W +: PC_W];
            end else if (m_redir && rdy) begin
                m_redir = 0;
            end
        end
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        logic [STAGES-1:0] s;
        logic [STAGES-1:0] fr;
        logic [STAGES*PC_W-1:0] p;

        rst = 1'b1; stall_req = '0; flush_req = '0; flush_pc = '0;
        redirect_ready = 1'b0; cnt_clr = 1'b0;
        m_redir = 0; m_rpc = '0; m_sc = 0; m_fe = 0; m_run = 0; m_to = 0;
        $display("[TB] starting");

        repeat (2) applyStimulus(1'b1, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);

        repeat (3) applyStimulus(1'b0, 5'b00100, 5'b00000, '0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 5'b10001, 5'b00000, '0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);

        applyStimulus(1'b0, 5'b00000, 5'b01000, pc_at(3, 32'h8000_0040), 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);

        repeat (2) applyStimulus(1'b0, 5'b01000, 5'b00100, pc_at(2, 32'h0000_0aa0), 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b00100, pc_at(2, 32'h0000_0aa0), 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b1, 1'b0);

        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'b00000, 5'b00010, pc_at(1, 32'h0000_0100), 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b10000, pc_at(4, 32'h0000_0200), 1'b1, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b1, 1'b0);

        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 5'b00010, 5'b00000, '0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);

        applyStimulus(1'b0, 5'b00000, 5'b00010, pc_at(1, 32'h0000_0300), 1'b0, 1'b0);
        applyStimulus(1'b1, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b0);

        // Long unbroken stall drives stall_cycles into saturation.
        repeat (70) applyStimulus(1'b0, 5'b00001, 5'b00000, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b0, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            s  = ($urandom % 3 == 0) ? (5'($urandom) & 5'($urandom)) : 5'b00000;
            fr = ($urandom % 4 == 0) ? (5'($urandom) & 5'($urandom)) : 5'b00000;
            p  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            applyStimulus(($urandom % 200 == 0), s, fr, p,
                          1'($urandom), ($urandom % 400 == 0));
        end
        applyStimulus(1'b0, 5'b00000, 5'b00000, '0, 1'b1, 1'b0);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0 pending", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline stall/flush controller for the core; generalises the fixed 5-stage stall mask generator. Takes per-stage stall and flush requests and produces per-stage stall, flush and bubble controls. Owns the fetch-redirect handshake after a flush, and adds stall/flush performance counters and a stall-timeout watchdog. Sits between the pipeline stages and the PC/fetch unit.

Parameters:
STAGES, 5, number of pipeline stages; index 0 = fetch, STAGES-1 = oldest stage.
PC_W, 32, redirect PC width.
CNT_W, 32, performance counter width.
TIMEOUT, 1024, consecutive stalled cycles before stall_timeout is set; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_req  in  STAGES  stage i requests a stall of itself and all younger stages
flush_req  in  STAGES  stage i requests a flush of stages 0..i-1 and a redirect
flush_pc  in  STAGES*PC_W  redirect target for stage i, in bits [i*PC_W +: PC_W]
stall  out  STAGES  per-stage hold
flush  out  STAGES  per-stage invalidate
bubble  out  STAGES  insert NOP into stage i
pc_stall  out  1  hold the PC register
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  PC_W  redirect target
redirect_ready  in  1  fetch accepts the redirect
cnt_clr  in  1  clear counters and the watchdog
stall_cycles  out  CNT_W  cycles with any stall bit set; saturating
flush_events  out  CNT_W  accepted flushes; saturating
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: already decided — one clock; reset is synchronous and active-high. While rst=1, every output is 0, the state is IDLE, and all counters are 0. The combinational outputs are also forced to 0 during rst.
- Stall and flush arbitration (combinational, same cycle):
  - k = highest index with stall_req set; stall[j]=1 for all j<=k, else stall=0.
  - f = highest index with flush_req set; the oldest requester wins and its flush_pc is taken.
  - A flush is accepted only if no stall exists or f>k. If accepted: flush[j]=1 for j<f, stall=0 for those stages, and flush_events increments.
  - If f<=k, the flush is not accepted, flush bits stay 0, and the stall applies. The requester holds flush_req.
  - bubble[i]=stall[i-1]&~stall[i]&~flush[i] for i>=1; bubble[0]=0.
- Redirect FSM (registered):
  - IDLE: on an accepted flush, load redirect_pc<=flush_pc[f], set redirect_valid<=1 and go to REDIRECT (redirect_valid is visible the next cycle).
  - REDIRECT: redirect_valid=1 and flush[0]=1 every cycle.
    - On redirect_valid&redirect_ready with no new accepted flush: redirect_valid<=0 and return to IDLE.
    - On a new accepted flush, with or without ready: load the new pc and stay in REDIRECT. If ready was high, the old redirect still counts as consumed.
- pc_stall = stall[0] | accepted flush this cycle | (state==REDIRECT).
- Counters:
  - stall_cycles increments by 1 each cycle with |stall.
  - flush_events increments by 1 per accepted flush.
  - Both saturate at all-ones.
  - cnt_clr clears both and has priority over an increment in the same cycle.
- Watchdog:
  - A run counter increments while |stall and clears when stall==0.
  - When the run reaches TIMEOUT, stall_timeout<=1. It stays set until rst or cnt_clr.
- Reset mid-REDIRECT aborts the redirect: redirect_valid=0 in the cycle rst is sampled.

Test Plan:
- STAGES=5, stall_req=5'b00100 -> stall=00111, bubble=01000, pc_stall=1; stall_cycles increments by 1 per cycle.
- stall_req=5'b10001 -> stall=11111, bubble=0. Then stall_req=0 -> stall=0 and the counter stops.
- flush_req=5'b01000, flush_pc[3]=0x80000040, no stall -> same-cycle flush=00111, pc_stall=1. Next cycle redirect_valid=1, redirect_pc=0x80000040. Hold ready=0 for 3 cycles -> flush[0]=1 throughout. Ready=1 -> IDLE next cycle, flush_events=1.
- flush_req=5'b00100 with stall_req=5'b01000 -> flush=0, stall=01111. Release the stall -> flush accepted that cycle with flush=00011.
- In REDIRECT (pc 0x100), a flush from stage 4 with pc 0x200 arrives together with redirect_ready=1 -> redirect_pc=0x200, redirect_valid stays 1, flush_events=2.
- TIMEOUT=4, stall_req[1] held 4 cycles -> stall_timeout=1 after the 4th stalled cycle. It stays 1 after the stall drops; cnt_clr -> 0 and stall_cycles=0. Assert rst in REDIRECT -> all outputs 0 next cycle.
